ieeedrv_sd_server: RTL and testbench

Image-side responder for the IEEE drive track loaders. It accepts per-subdrive track read/write requests (LBA, block count, rd/wr strobes) and arbitrates them onto the single host image port. It returns a per-subdrive ack that brackets the transfer, and moves 256-byte blocks between the host block buffer and the owning subdrive's track RAM. It sits between the track loader's `sd_*` outputs and the HPS image interface.

---
 rtl/ieeedrv_sd_server.sv | 203 ++++++++++++++++++++
 tb/tb_ieeedrv_sd_server.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieeedrv_sd_server.sv
// Purpose: arbitrates per-subdrive track read/write requests onto the single host image port
//          and moves 256-byte blocks between the host block buffer and the owner's track RAM.
// Latency: grant 1 clk after request seen in IDLE; track RAM write 1 clk after img_buff_wr;
//          write-direction data 1 clk after address.
// Backpressure: none on the data path; the host paces bytes. Requests wait in IDLE until granted.
// Ports: req_* per-client request side, img_* host image side, tbuf_* per-client track RAM side.
module ieeedrv_sd_server #(
    parameter int SUBDRV  = 2,
    parameter int TBUF_AW = 13
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [31:0]        req_lba     [SUBDRV],
    input  logic [5:0]         req_blk_cnt [SUBDRV],
    input  logic [SUBDRV-1:0]  req_rd,
    input  logic [SUBDRV-1:0]  req_wr,
    output logic [SUBDRV-1:0]  req_ack,
    output logic [31:0]        img_lba,
    output logic [5:0]         img_blk_cnt,
    output logic               img_rd,
    output logic               img_wr,
    input  logic               img_ack,
    input  logic [7:0]         img_buff_addr,
    input  logic [7:0]         img_buff_dout,
    input  logic               img_buff_wr,
    output logic [7:0]         img_buff_din,
    output logic [TBUF_AW-1:0] tbuf_addr,
    output logic [7:0]         tbuf_din,
    output logic [SUBDRV-1:0]  tbuf_we,
    input  logic [7:0]         tbuf_dout   [SUBDRV]
);
    localparam int            OW = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;
    localparam logic [OW-1:0] NS = OW'(SUBDRV - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

    // Reset asserts asynchronously through the synchronizer so every output clears at once;
    // release is delayed by two clocks.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t             state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_q, last_d;
    logic [31:0]        lba_q, lba_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [5:0]         blk_q, blk_d;
    logic               dir_wr_q, dir_wr_d;
    logic               ovr_q, ovr_d;
    logic [7:0]         addr_prev_q, addr_prev_d;
    logic               img_rd_q, img_rd_d;
    logic               img_wr_q, img_wr_d;
    logic [SUBDRV-1:0]  req_ack_q, req_ack_d;
    logic [SUBDRV-1:0]  tbuf_we_q, tbuf_we_d;
    logic [TBUF_AW-1:0] tbuf_addr_q, tbuf_addr_d;
    logic [7:0]         tbuf_din_q, tbuf_din_d;

    logic               wrap;
    logic               found;
    int                 cand;
    logic [OW-1:0]      cand_ow;
    logic [TBUF_AW-1:0] xfer_addr;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        lba_d       = lba_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        dir_wr_d    = dir_wr_q;
        ovr_d       = ovr_q;
        addr_prev_d = addr_prev_q;
        img_rd_d    = img_rd_q;
        img_wr_d    = img_wr_q;
        req_ack_d   = req_ack_q;
        tbuf_we_d   = '0;
        tbuf_addr_d = tbuf_addr_q;
        tbuf_din_d  = tbuf_din_q;
        found       = 1'b0;
        cand        = 0;
        cand_ow     = '0;

        // A 255 -> 0 step of the host address starts the next block. Once the last
        // requested block is reached, a further wrap marks the rest of the stream as overrun.
        wrap = (state_q == S_XFER) && (addr_prev_q == 8'hFF) && (img_buff_addr == 8'h00);
        if (wrap) begin
            if (blk_q != cnt_q) blk_d = blk_q + 6'd1;
            else                ovr_d = 1'b1;
        end
        // Uses the updated block so byte 0 of a new block lands in the new block.
        xfer_addr = TBUF_AW'({blk_d, img_buff_addr});

        case (state_q)
            S_IDLE: begin
                // Round-robin scan starting after the last granted client.
                for (int i = 1; i <= SUBDRV; i++) begin
                    cand = int'(last_q) + i;
                    if (cand >= SUBDRV) cand = cand - SUBDRV;
                    cand_ow = OW'(cand);
                    if (!found && (req_rd[cand_ow] || req_wr[cand_ow])) begin
                        found    = 1'b1;
                        owner_d  = cand_ow;
                        lba_d    = req_lba[cand_ow];
                        cnt_d    = req_blk_cnt[cand_ow];
                        dir_wr_d = req_wr[cand_ow];
                    end
                end
                if (found) begin
                    blk_d    = '0;
                    ovr_d    = 1'b0;
                    img_rd_d = !dir_wr_d;
                    img_wr_d = dir_wr_d;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                addr_prev_d = '0;
                if (img_ack) begin
                    img_rd_d           = 1'b0;
                    img_wr_d           = 1'b0;
                    req_ack_d          = '0;
                    req_ack_d[owner_q] = 1'b1;
                    state_d            = S_XFER;
                end
            end
            S_XFER: begin
                addr_prev_d        = img_buff_addr;
                req_ack_d          = '0;
                req_ack_d[owner_q] = img_ack;
                if (!dir_wr_q && img_buff_wr && !ovr_d) begin
                    tbuf_we_d[owner_q] = 1'b1;
                    tbuf_din_d         = img_buff_dout;
                    tbuf_addr_d        = xfer_addr;
                end
                // Only entered with img_ack high, so a low level here is its falling edge.
                if (!img_ack) state_d = S_DONE;
            end
            S_DONE: begin
                req_ack_d = '0;
                last_d    = owner_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            last_q      <= NS;
            lba_q       <= '0;
            cnt_q       <= '0;
            blk_q       <= '0;
            dir_wr_q    <= 1'b0;
            ovr_q       <= 1'b0;
            addr_prev_q <= '0;
            img_rd_q    <= 1'b0;
            img_wr_q    <= 1'b0;
            req_ack_q   <= '0;
            tbuf_we_q   <= '0;
            tbuf_addr_q <= '0;
            tbuf_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lba_q       <= lba_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            dir_wr_q    <= dir_wr_d;
            ovr_q       <= ovr_d;
            addr_prev_q <= addr_prev_d;
            img_rd_q    <= img_rd_d;
            img_wr_q    <= img_wr_d;
            req_ack_q   <= req_ack_d;
            tbuf_we_q   <= tbuf_we_d;
            tbuf_addr_q <= tbuf_addr_d;
            tbuf_din_q  <= tbuf_din_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign img_lba     = lba_q;
    assign img_blk_cnt = cnt_q;
    assign img_rd      = img_rd_q;
    assign img_wr      = img_wr_q;
    assign tbuf_we     = tbuf_we_q;
    assign tbuf_din    = tbuf_din_q;

    // Write direction reads the RAM straight from the host address; the RAM's own
    // register supplies the one-cycle data lag. Gated by state so reset forces zeros.
    assign tbuf_addr    = (state_q == S_XFER && dir_wr_q) ? xfer_addr : tbuf_addr_q;
    assign img_buff_din = (state_q == S_XFER && dir_wr_q) ? tbuf_dout[owner_q] : 8'h00;

endmodule

// File: tb/tb_ieeedrv_sd_server.sv
module tb_ieeedrv_sd_server;
    localparam int SUBDRV  = 2;
    localparam int TBUF_AW = 13;
    localparam int AMASK   = (1 << TBUF_AW) - 1;

    logic               clk_sys = 1'b0;
    logic               reset_n = 1'b1;
    logic [31:0]        req_lba     [SUBDRV];
    logic [5:0]         req_blk_cnt [SUBDRV];
    logic [SUBDRV-1:0]  req_rd, req_wr, req_ack, tbuf_we;
    logic [31:0]        img_lba;
    logic [5:0]         img_blk_cnt;
    logic               img_rd, img_wr, img_ack, img_buff_wr;
    logic [7:0]         img_buff_addr, img_buff_dout, img_buff_din, tbuf_din;
    logic [TBUF_AW-1:0] tbuf_addr;
    logic [7:0]         tbuf_dout   [SUBDRV];

    logic [7:0] mem [SUBDRV][1 << TBUF_AW];
    logic       pl_en;
    int         pl_c, pl_a;
    logic [7:0] pl_d;
    logic [7:0] hdat [1024];
    logic [7:0] pre  [1024];
    int         wlog[$];
    int         exp_q[$];
    int         checks = 0;
    int         errors = 0;

    ieeedrv_sd_server #(.SUBDRV(SUBDRV), .TBUF_AW(TBUF_AW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .req_lba(req_lba), .req_blk_cnt(req_blk_cnt), .req_rd(req_rd), .req_wr(req_wr),
        .req_ack(req_ack), .img_lba(img_lba), .img_blk_cnt(img_blk_cnt),
        .img_rd(img_rd), .img_wr(img_wr), .img_ack(img_ack),
        .img_buff_addr(img_buff_addr), .img_buff_dout(img_buff_dout), .img_buff_wr(img_buff_wr),
        .img_buff_din(img_buff_din), .tbuf_addr(tbuf_addr), .tbuf_din(tbuf_din),
        .tbuf_we(tbuf_we), .tbuf_dout(tbuf_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Track RAMs: one-cycle read latency, read-before-write, plus a preload port.
    always @(posedge clk_sys) begin
        for (int c = 0; c < SUBDRV; c++) begin
            tbuf_dout[c] <= mem[c][tbuf_addr];
            if (tbuf_we[c]) mem[c][tbuf_addr] <= tbuf_din;
        end
        if (pl_en) mem[pl_c][pl_a] <= pl_d;
    end

    // Every track RAM write as {client, address, data}.
    always @(negedge clk_sys)
        for (int c = 0; c < SUBDRV; c++)
            if (tbuf_we[c]) wlog.push_back((c << 24) | (int'(tbuf_addr) << 8) | int'(tbuf_din));

    function automatic int ent(input int c, input int a, input int d);
        return (c << 24) | ((a & AMASK) << 8) | (d & 255);
    endfunction

    // Host streams n bytes; only bytes inside the requested blocks reach the RAM.
    task automatic model_read(input int c, input int cnt, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++)
            if (k < (cnt + 1) * 256) exp_q.push_back(ent(c, k, int'(hdat[k])));
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic idle_in();
        req_rd = '0; req_wr = '0; img_ack = 1'b0;
        img_buff_addr = '0; img_buff_dout = '0; img_buff_wr = 1'b0;
        pl_en = 1'b0; pl_c = 0; pl_a = 0; pl_d = '0;
        for (int c = 0; c < SUBDRV; c++) begin
            req_lba[c] = '0; req_blk_cnt[c] = '0;
        end
    endtask

    task automatic request(input int c, input logic [31:0] lba, input int cnt, input bit rd, input bit wr);
        req_lba[c] = lba; req_blk_cnt[c] = 6'(cnt); req_rd[c] = rd; req_wr[c] = wr;
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (img_rd || img_wr) begin cyc = i; break; end
        end
    endtask

    task automatic stream_rd(input int n);
        for (int k = 0; k < n; k++) begin
            img_buff_addr = 8'(k % 256); img_buff_dout = hdat[k]; img_buff_wr = 1'b1;
            tick();
        end
        img_buff_wr = 1'b0; img_buff_addr = '0;
    endtask

    task automatic preload(input int c, input int n);
        for (int a = 0; a < n; a++) begin
            pl_en = 1'b1; pl_c = c; pl_a = a; pl_d = pre[a];
            tick();
        end
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [80:0] outs;
        idle_in();
        #2 reset_n = 1'b0;
        #1;
        outs = {req_ack, img_lba, img_blk_cnt, img_rd, img_wr, img_buff_din, tbuf_addr, tbuf_din, tbuf_we};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h required 0", outs); end
        tick(2);
        reset_n = 1'b1;
        tick(4);
        img_ack = 1'b1;
        tick(3);
        checks++;
        if (img_rd !== 1'b0 || img_wr !== 1'b0 || req_ack !== '0) begin
            errors++; $display("FAIL spurious_ack: rd %b wr %b ack %b required 0 0 00", img_rd, img_wr, req_ack);
        end
        img_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_single_read();
        int cyc, base, bad;
        for (int k = 0; k < 768; k++) hdat[k] = 8'((k % 256) ^ (k / 256));
        base = wlog.size();
        request(0, 32'h40, 2, 1'b1, 1'b0);
        wait_strobe(cyc);
        checks++;
        if (cyc !== 1 || img_rd !== 1'b1 || img_wr !== 1'b0) begin
            errors++; $display("FAIL rd_grant: cycles %0d rd %b wr %b required 1 1 0", cyc, img_rd, img_wr);
        end
        checks++;
        if (img_lba !== 32'h40 || img_blk_cnt !== 6'd2) begin
            errors++; $display("FAIL rd_cmd: lba %h cnt %0d required 40 2", img_lba, img_blk_cnt);
        end
        img_ack = 1'b1;
        tick();
        checks++;
        if (req_ack !== 2'b01 || img_rd !== 1'b0) begin
            errors++; $display("FAIL rd_ack_rise: ack %b rd %b required 01 0", req_ack, img_rd);
        end
        req_rd = '0;
        stream_rd(768);
        checks++;
        if (req_ack !== 2'b01) begin errors++; $display("FAIL rd_ack_hold: ack %b required 01", req_ack); end
        img_ack = 1'b0;
        tick();
        checks++;
        if (req_ack !== 2'b00) begin errors++; $display("FAIL rd_ack_fall: ack %b required 00", req_ack); end
        tick();
        model_read(0, 2, 768);
        bad = -1;
        if (wlog.size() - base != exp_q.size()) bad = -2;
        else for (int i = 0; i < exp_q.size(); i++) if (wlog[base + i] != exp_q[i]) begin bad = i; break; end
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL rd_log: %0d writes first bad %0d required %0d writes", wlog.size() - base, bad, exp_q.size());
        end
    endtask

    task automatic test_single_write();
        int cyc, base, bad;
        logic [7:0] got, want;
        for (int a = 0; a < 256; a++) pre[a] = 8'(8'hA5 ^ 8'(a));
        preload(1, 256);
        base = wlog.size();
        request(1, 32'h1234, 0, 1'b0, 1'b1);
        wait_strobe(cyc);
        checks++;
        if (cyc !== 1 || img_wr !== 1'b1 || img_rd !== 1'b0 || img_lba !== 32'h1234) begin
            errors++; $display("FAIL wr_grant: cycles %0d wr %b rd %b lba %h required 1 1 0 1234", cyc, img_wr, img_rd, img_lba);
        end
        img_ack = 1'b1;
        tick();
        checks++;
        if (req_ack !== 2'b10) begin errors++; $display("FAIL wr_ack_rise: ack %b required 10", req_ack); end
        req_wr = '0;
        bad = -1; got = '0; want = '0;
        for (int k = 0; k < 256; k++) begin
            img_buff_addr = 8'(k);
            tick();
            if (bad < 0 && img_buff_din !== (8'hA5 ^ 8'(k))) begin
                bad = k; got = img_buff_din; want = 8'hA5 ^ 8'(k);
            end
        end
        img_buff_addr = '0;
        checks++;
        if (bad != -1) begin errors++; $display("FAIL wr_data: addr %0d got %h required %h", bad, got, want); end
        img_ack = 1'b0;
        tick();
        checks++;
        if (req_ack !== 2'b00) begin errors++; $display("FAIL wr_ack_fall: ack %b required 00", req_ack); end
        tick();
        checks++;
        if (wlog.size() != base) begin errors++; $display("FAIL wr_no_tbuf_we: %0d writes required 0", wlog.size() - base); end
    endtask

    task automatic test_contention();
        int cyc;
        request(0, 32'h100, 0, 1'b1, 1'b0);
        request(1, 32'h200, 0, 1'b1, 1'b0);
        wait_strobe(cyc);
        checks++;
        if (cyc !== 1 || img_lba !== 32'h100) begin errors++; $display("FAIL cont_first: lba %h required 100", img_lba); end
        img_ack = 1'b1;
        tick();
        checks++;
        if (req_ack !== 2'b01) begin errors++; $display("FAIL cont_ack0: ack %b required 01", req_ack); end
        req_rd[0] = 1'b0;
        img_ack = 1'b0;
        tick(2);
        checks++;
        if (img_rd !== 1'b0) begin errors++; $display("FAIL cont_gap: rd %b required 0", img_rd); end
        tick();
        checks++;
        if (img_rd !== 1'b1 || img_lba !== 32'h200) begin
            errors++; $display("FAIL cont_second: rd %b lba %h required 1 200", img_rd, img_lba);
        end
        img_ack = 1'b1;
        tick();
        checks++;
        if (req_ack !== 2'b10) begin errors++; $display("FAIL cont_ack1: ack %b required 10", req_ack); end
        req_rd[1] = 1'b0;
        img_ack = 1'b0;
        tick(2);
        // Second round: client 0 keeps requesting after being served.
        request(0, 32'h100, 0, 1'b1, 1'b0);
        request(1, 32'h200, 0, 1'b1, 1'b0);
        wait_strobe(cyc);
        checks++;
        if (cyc < 0 || img_lba !== 32'h100) begin errors++; $display("FAIL rr2_first: lba %h required 100", img_lba); end
        img_ack = 1'b1;
        tick();
        img_ack = 1'b0;
        tick(2);
        wait_strobe(cyc);
        checks++;
        if (cyc < 0 || img_lba !== 32'h200) begin errors++; $display("FAIL rr2_fair: lba %h required 200", img_lba); end
        img_ack = 1'b1;
        tick();
        req_rd = '0;
        img_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_collision();
        int cyc;
        request(0, 32'h55, 0, 1'b1, 1'b1);
        wait_strobe(cyc);
        checks++;
        if (cyc !== 1 || img_wr !== 1'b1 || img_rd !== 1'b0) begin
            errors++; $display("FAIL collision: wr %b rd %b required 1 0", img_wr, img_rd);
        end
        img_ack = 1'b1;
        tick();
        req_rd = '0; req_wr = '0;
        img_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_overrun();
        int cyc, base, bad;
        for (int k = 0; k < 512; k++) hdat[k] = 8'($urandom);
        base = wlog.size();
        request(0, 32'h300, 0, 1'b1, 1'b0);
        wait_strobe(cyc);
        img_ack = 1'b1;
        tick();
        req_rd = '0;
        stream_rd(512);
        img_ack = 1'b0;
        tick(2);
        model_read(0, 0, 512);
        bad = -1;
        if (cyc < 0 || wlog.size() - base != exp_q.size()) bad = -2;
        else for (int i = 0; i < exp_q.size(); i++) if (wlog[base + i] != exp_q[i]) begin bad = i; break; end
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL overrun: %0d writes first bad %0d required %0d writes", wlog.size() - base, bad, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_xfer();
        int cyc;
        for (int k = 0; k < 512; k++) hdat[k] = 8'($urandom);
        request(0, 32'h77, 1, 1'b1, 1'b0);
        wait_strobe(cyc);
        img_ack = 1'b1;
        tick();
        req_rd = '0;
        for (int k = 0; k < 100; k++) begin
            img_buff_addr = 8'(k); img_buff_dout = hdat[k]; img_buff_wr = 1'b1;
            tick();
        end
        img_buff_addr = 8'd100; img_buff_dout = hdat[100];
        checks++;
        if (tbuf_we !== 2'b01 || req_ack !== 2'b01) begin
            errors++; $display("FAIL rst_pre: we %b ack %b required 01 01", tbuf_we, req_ack);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (req_ack !== '0 || tbuf_we !== '0 || img_rd !== 1'b0 || img_lba !== '0 || tbuf_addr !== '0) begin
            errors++; $display("FAIL rst_async: ack %b we %b rd %b lba %h addr %h required all 0", req_ack, tbuf_we, img_rd, img_lba, tbuf_addr);
        end
        idle_in();
        tick(2);
        reset_n = 1'b1;
        tick(4);
        request(1, 32'h99, 0, 1'b1, 1'b0);
        wait_strobe(cyc);
        checks++;
        if (cyc !== 1 || img_rd !== 1'b1 || img_lba !== 32'h99) begin
            errors++; $display("FAIL rst_regrant: cycles %0d rd %b lba %h required 1 1 99", cyc, img_rd, img_lba);
        end
        img_ack = 1'b1;
        tick();
        checks++;
        if (req_ack !== 2'b10) begin errors++; $display("FAIL rst_ack: ack %b required 10", req_ack); end
        req_rd = '0;
        img_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_random();
        int c, cnt, n, cyc, base, bad;
        bit wr;
        logic [31:0] lba;
        logic [1:0]  ev;
        for (int t = 0; t < 6; t++) begin
            c   = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            cnt = int'($urandom_range(0, 2));
            lba = $urandom;
            ev  = 2'(1 << c);
            if (wr) begin
                n = (cnt + 1) * 256;
                for (int a = 0; a < n; a++) pre[a] = 8'($urandom);
                preload(c, n);
            end else begin
                n = int'($urandom_range(1, (cnt + 2) * 256));
                for (int k = 0; k < n; k++) hdat[k] = 8'($urandom);
            end
            base = wlog.size();
            request(c, lba, cnt, !wr, wr);
            wait_strobe(cyc);
            checks++;
            if (cyc !== 1 || img_lba !== lba || img_blk_cnt !== 6'(cnt) || img_wr !== wr || img_rd !== !wr) begin
                errors++; $display("FAIL rnd_cmd %0d: lba %h cnt %0d wr %b rd %b required %h %0d %b %b", t, img_lba, img_blk_cnt, img_wr, img_rd, lba, cnt, wr, !wr);
            end
            img_ack = 1'b1;
            tick();
            checks++;
            if (req_ack !== ev) begin errors++; $display("FAIL rnd_ack %0d: ack %b required %b", t, req_ack, ev); end
            req_rd = '0; req_wr = '0;
            bad = -1;
            if (wr) begin
                for (int k = 0; k < n; k++) begin
                    img_buff_addr = 8'(k % 256);
                    tick();
                    if (bad < 0 && img_buff_din !== pre[k]) bad = k;
                end
                img_buff_addr = '0;
            end else begin
                stream_rd(n);
            end
            img_ack = 1'b0;
            tick();
            checks++;
            if (req_ack !== '0) begin errors++; $display("FAIL rnd_fall %0d: ack %b required 00", t, req_ack); end
            tick();
            if (wr) begin
                if (wlog.size() != base) bad = -2;
            end else begin
                model_read(c, cnt, n);
                if (wlog.size() - base != exp_q.size()) bad = -2;
                else for (int i = 0; i < exp_q.size(); i++) if (wlog[base + i] != exp_q[i]) begin bad = i; break; end
            end
            checks++;
            if (bad != -1) begin
                errors++; $display("FAIL rnd_data %0d: wr %b first bad %0d writes %0d required %0d", t, wr, bad, wlog.size() - base, wr ? 0 : exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_collision();
        test_overrun();
        test_reset_mid_xfer();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
